// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the datapath and pipeline_hazard_ctrl.
// master: datapath side (drives hazard info, consumes stage enables/flushes).
// slave : controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              mc_start;
  logic              mc_done;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           branch_taken, mc_start, mc_done,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           branch_taken, mc_start, mc_done,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage-register enables and bubble flushes
// for load-use stalls, taken branches and multi-cycle EX ops.
// Optional feature macro: STALL_COUNTER_EN (stall-cycle performance counter).
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t            state, nxt;
  logic [REG_AW-1:0] ex_rd;
  logic              load_use;
  logic              go;
  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl}
  logic [7:0]        ctl;

  assign ex_rd = hz.ex_rd;
  assign go    = Tick & Reset;

  // Load-use: ID reads the register a load in EX has not yet produced.
  assign load_use = hz.ex_mem_read && (ex_rd != '0) &&
                    ((hz.id_uses_rs && (hz.id_rs == ex_rd)) ||
                     (hz.id_uses_rt && (hz.id_rt == ex_rd)));

  // Priority decode: MC_WAIT > mc_start > branch > load-use.
  always_comb begin
    ctl = 8'b11111_000;
    nxt = state;
    if (state == MC_WAIT) begin
      if (hz.mc_done) nxt = RUN;          // result captured, front resumes
      else            ctl = 8'b00011_001; // front frozen, bubbles to MEM
    end else if (hz.mc_start) begin
      if (!hz.mc_done) begin              // same-cycle done = 1-cycle op
        ctl = 8'b00001_000;
        nxt = MC_WAIT;
      end
    end else if (hz.branch_taken) begin
      ctl = 8'b11111_110;                 // squash IF and ID, PC takes target
    end else if (load_use) begin
      ctl = 8'b00111_010;                 // hold IF/ID+PC, one bubble into EX
    end
  end

  assign {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
          hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush} = ctl & {8{go}};

  // State advances only on Tick; Reset drops any pending multi-cycle wait.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    state <= RUN;
    else if (Tick) state <= nxt;
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] cnt_q;

  // Count stepped cycles in which the PC is held.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)               cnt_q <= '0;
    else if (Tick && !ctl[7]) cnt_q <= cnt_q + 1'b1;
  end

  assign hz.stall_cnt = cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized stimulus checked against a
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;   // narrow counter so wrap-around happens in the random run

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Tick  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .hz    (hz.slave)
  );

  always #5 Clock = ~Clock;

  // model state
  bit          m_busy = 1'b0;   // a multi-cycle op is outstanding
  int unsigned m_cnt  = 0;
  logic [7:0]  m_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
            hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush};
  endfunction

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb,if_id_fl,id_ex_fl,ex_mem_fl}
  function automatic logic [7:0] ref_out();
    bit dep_rs, dep_rt;
    if (!Reset || !Tick) return 8'h00;
    dep_rs = hz.id_uses_rs && hz.id_rs == hz.ex_rd;
    dep_rt = hz.id_uses_rt && hz.id_rt == hz.ex_rd;
    if (m_busy)                  return hz.mc_done ? 8'b11111_000 : 8'b00011_001;
    if (hz.mc_start)             return hz.mc_done ? 8'b11111_000 : 8'b00001_000;
    if (hz.branch_taken)         return 8'b11111_110;
    if (hz.ex_mem_read && hz.ex_rd != 0 && (dep_rs || dep_rt))
                                 return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  task automatic idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = '0; hz.branch_taken = 1'b0;
    hz.mc_start = 1'b0; hz.mc_done = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied: check, then step the model.
  task automatic cyc(input string tag, input logic [7:0] dir, input bit use_dir);
    logic [31:0] exp_cnt;
    #1;
    m_exp = ref_out();
    chk({tag, "/mdl"}, {24'h0, outs()}, {24'h0, m_exp});
    if (use_dir) chk({tag, "/dir"}, {24'h0, outs()}, {24'h0, dir});
`ifdef STALL_COUNTER_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk({tag, "/cnt"}, {{(32-CW){1'b0}}, hz.stall_cnt}, exp_cnt);
    @(posedge Clock);
    if (!Reset) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (Tick) begin
      if (!m_exp[7]) m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_busy && hz.mc_done)                       m_busy = 1'b0;
      else if (!m_busy && hz.mc_start && !hz.mc_done) m_busy = 1'b1;
    end
    @(negedge Clock);
  endtask

  initial begin
    idle();
    Reset = 1'b0;
    Tick  = 1'b1;
    @(negedge Clock);
    // reset held three cycles: everything off
    for (int i = 0; i < 3; i++) cyc("rst", 8'h00, 1'b1);
    Reset = 1'b1;
    cyc("run", 8'b11111_000, 1'b1);

    // load-use through rs, one bubble only
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1;
    cyc("lu_rs", 8'b00111_010, 1'b1);
    idle();
    cyc("lu_next", 8'b11111_000, 1'b1);
    // load-use through rt
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b1;
    cyc("lu_rt", 8'b00111_010, 1'b1);
    // register 0 never stalls
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs = 5'd0; hz.id_uses_rs = 1'b1;
    cyc("rd0", 8'b11111_000, 1'b1);
    // branch beats load-use
    hz.ex_rd = 5'd5; hz.id_rs = 5'd5; hz.branch_taken = 1'b1;
    cyc("br", 8'b11111_110, 1'b1);
    idle();

    // multi-cycle op: done arrives four cycles after start
    hz.mc_start = 1'b1;
    cyc("mc_s", 8'b00001_000, 1'b1);
    hz.mc_start = 1'b0;
    cyc("mc_w", 8'b00011_001, 1'b1);
    hz.branch_taken = 1'b1;   // ignored while waiting
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs = 5'd3; hz.id_uses_rs = 1'b1;
    cyc("mc_w_br", 8'b00011_001, 1'b1);
    idle();
    cyc("mc_w", 8'b00011_001, 1'b1);
    hz.mc_done = 1'b1;
    cyc("mc_d", 8'b11111_000, 1'b1);
    idle();
    cyc("mc_run", 8'b11111_000, 1'b1);

    // Tick low while waiting with done held: frozen, then completes
    hz.mc_start = 1'b1;
    cyc("t_s", 8'b00001_000, 1'b1);
    hz.mc_start = 1'b0; hz.mc_done = 1'b1; Tick = 1'b0;
    cyc("t_frz", 8'h00, 1'b1);
    cyc("t_frz", 8'h00, 1'b1);
    Tick = 1'b1;
    cyc("t_d", 8'b11111_000, 1'b1);
    idle();
    cyc("t_run", 8'b11111_000, 1'b1);

    // one-cycle op: start and done together stays in RUN
    hz.mc_start = 1'b1; hz.mc_done = 1'b1;
    cyc("mc1", 8'b11111_000, 1'b1);
    idle();
    cyc("mc1_run", 8'b11111_000, 1'b1);

    // reset during a wait returns to RUN
    hz.mc_start = 1'b1;
    cyc("rm_s", 8'b00001_000, 1'b1);
    idle();
    Reset = 1'b0;
    cyc("rm_rst", 8'h00, 1'b1);
    Reset = 1'b1;
    cyc("rm_run", 8'b11111_000, 1'b1);

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      Reset           = ($urandom_range(0, 99) != 0);
      Tick            = ($urandom_range(0, 7) != 0);
      hz.id_rs        = AW'($urandom_range(0, 3));
      hz.id_rt        = AW'($urandom_range(0, 3));
      hz.ex_rd        = AW'($urandom_range(0, 3));
      hz.id_uses_rs   = $urandom_range(0, 1) == 1;
      hz.id_uses_rt   = $urandom_range(0, 1) == 1;
      hz.ex_mem_read  = $urandom_range(0, 1) == 1;
      hz.branch_taken = $urandom_range(0, 5) == 0;
      hz.mc_start     = $urandom_range(0, 7) == 0;
      hz.mc_done      = $urandom_range(0, 3) == 0;
      cyc("rnd", 8'h00, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
